// File: rtl/ra_ddr_seq.sv
// Double-data-rate array sequencer: two request ports share one array, each owning
// alternate clk slots selected by el_sel; reads return through a fixed-latency pipeline.
module ra_ddr_seq #(
   parameter int ADDR_W = 6,
   parameter int DATA_W = 32,
   parameter int RD_LAT = 1
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              el_sel,
   input  logic              p0_req_val,
   output logic              p0_req_rdy,
   input  logic              p0_req_we,
   input  logic [ADDR_W-1:0] p0_req_addr,
   input  logic [DATA_W-1:0] p0_req_wdata,
   output logic              p0_rsp_val,
   output logic [DATA_W-1:0] p0_rsp_data,
   input  logic              p1_req_val,
   output logic              p1_req_rdy,
   input  logic              p1_req_we,
   input  logic [ADDR_W-1:0] p1_req_addr,
   input  logic [DATA_W-1:0] p1_req_wdata,
   output logic              p1_rsp_val,
   output logic [DATA_W-1:0] p1_rsp_data,
   output logic              arr_rd,
   output logic              arr_wr,
   output logic [ADDR_W-1:0] arr_addr,
   output logic [DATA_W-1:0] arr_wdata,
   input  logic [DATA_W-1:0] arr_rdata,
   output logic              phase_err
);

   typedef struct packed {
      logic              we;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] wdata;
   } req_t;

   req_t [1:0] req_in;
   req_t [1:0] head;
   req_t       cur;
   logic [1:0] req_val;
   logic [1:0] req_rdy;
   logic [1:0] not_empty;
   logic [1:0] pop;

   assign req_in[0] = {p0_req_we, p0_req_addr, p0_req_wdata};
   assign req_in[1] = {p1_req_we, p1_req_addr, p1_req_wdata};
   assign req_val   = {p1_req_val, p0_req_val};
   assign p0_req_rdy = req_rdy[0];
   assign p1_req_rdy = req_rdy[1];

   for (genvar k = 0; k < 2; k++) begin : g_port
      req_t       mem [2];
      logic       wr_ptr;
      logic       rd_ptr;
      logic [1:0] count;
      logic       push;

      // rdy is forced low while reset is held, not just when the FIFO is full.
      assign req_rdy[k]   = reset_n & (count != 2'd2);
      assign push         = req_val[k] & req_rdy[k];
      assign not_empty[k] = (count != 2'd0);
      assign head[k]      = mem[rd_ptr];

      // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
      always_ff @(posedge clk or negedge reset_n) begin
         if (!reset_n) begin
            count  <= 2'd0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
         end else begin
            if (push)   wr_ptr <= ~wr_ptr;
            if (pop[k]) rd_ptr <= ~rd_ptr;
            count <= count + 2'(push) - 2'(pop[k]);
         end
      end

      // NOTE: FIFO storage is not reset; count and pointers alone define which entries are live.
      always_ff @(posedge clk) begin
         if (push) mem[wr_ptr] <= req_in[k];
      end
   end

   logic prev_sel;
   logic prev_vld;
   logic phase_hit;
   logic issue;

   // The first cycle after reset has no previous el_sel to compare against.
   assign phase_hit = prev_vld & (el_sel == prev_sel);
   assign cur       = head[el_sel];
   assign issue     = not_empty[el_sel] & ~phase_hit;
   assign pop       = {issue & el_sel, issue & ~el_sel};
   assign arr_rd    = issue & ~cur.we;
   assign arr_wr    = issue & cur.we;
   assign arr_addr  = cur.addr;
   assign arr_wdata = cur.wdata;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         prev_sel  <= 1'b0;
         prev_vld  <= 1'b0;
         phase_err <= 1'b0;
      end else begin
         prev_sel <= el_sel;
         prev_vld <= 1'b1;
         if (phase_hit) phase_err <= 1'b1;
      end
   end

   logic [RD_LAT-1:0] pipe_vld;
   logic [RD_LAT-1:0] pipe_port;
   logic              rsp_hit;
   logic              rsp_port;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pipe_vld  <= '0;
         pipe_port <= '0;
      end else begin
         pipe_vld[0]  <= arr_rd;
         pipe_port[0] <= el_sel;
         for (int i = 1; i < RD_LAT; i++) begin
            pipe_vld[i]  <= pipe_vld[i-1];
            pipe_port[i] <= pipe_port[i-1];
         end
      end
   end

   assign rsp_hit  = pipe_vld[RD_LAT-1];
   assign rsp_port = pipe_port[RD_LAT-1];

   // Response data holds its last value until that port's next read returns.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         p0_rsp_val  <= 1'b0;
         p1_rsp_val  <= 1'b0;
         p0_rsp_data <= '0;
         p1_rsp_data <= '0;
      end else begin
         p0_rsp_val <= rsp_hit & ~rsp_port;
         p1_rsp_val <= rsp_hit & rsp_port;
         if (rsp_hit & ~rsp_port) p0_rsp_data <= arr_rdata;
         if (rsp_hit & rsp_port)  p1_rsp_data <= arr_rdata;
      end
   end

endmodule

// File: tb/tb_ra_ddr_seq.sv
// Directed bench for ra_ddr_seq: three instances (RD_LAT 1, 3, 4) share stimulus,
// each with its own small array model.
module tb_ra_ddr_seq;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        el_sel = 1'b0;
   logic        tgl = 1'b0;
   logic        p0_req_val = 1'b0, p0_req_we = 1'b0;
   logic [5:0]  p0_req_addr = '0;
   logic [31:0] p0_req_wdata = '0;
   logic        p1_req_val = 1'b0, p1_req_we = 1'b0;
   logic [5:0]  p1_req_addr = '0;
   logic [31:0] p1_req_wdata = '0;

   logic [2:0]  p0_req_rdy_a, p1_req_rdy_a, p0_rsp_val_a, p1_rsp_val_a;
   logic [2:0]  arr_rd_a, arr_wr_a, phase_err_a;
   logic [31:0] p0_rsp_data_a [3];
   logic [31:0] p1_rsp_data_a [3];
   logic [31:0] arr_wdata_a [3];
   logic [5:0]  arr_addr_a [3];

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   function automatic logic [31:0] pat(input int a);
      return 32'hC0DE_0000 | 32'(a);
   endfunction

   for (genvar g = 0; g < 3; g++) begin : g_inst
      localparam int LAT = (g == 0) ? 1 : (g == 1) ? 3 : 4;
      logic [31:0] dly [LAT];
      logic [31:0] rdata;
      logic        wv;
      logic [5:0]  wa;
      logic [31:0] wd;

      // Array model: unwritten locations read back pat(addr); last write wins.
      always @(posedge clk or negedge reset_n) begin
         if (!reset_n) wv <= 1'b0;
         else if (arr_wr_a[g]) begin
            wv <= 1'b1;
            wa <= arr_addr_a[g];
            wd <= arr_wdata_a[g];
         end
      end

      always @(posedge clk) begin
         dly[0] <= !arr_rd_a[g] ? 32'hDEAD_BEEF :
                   (wv && wa == arr_addr_a[g]) ? wd : pat(int'(arr_addr_a[g]));
         for (int i = 1; i < LAT; i++) dly[i] <= dly[i-1];
      end
      assign rdata = dly[LAT-1];

      ra_ddr_seq #(.ADDR_W(6), .DATA_W(32), .RD_LAT(LAT)) u_dut (
         .clk          (clk),
         .reset_n      (reset_n),
         .el_sel       (el_sel),
         .p0_req_val   (p0_req_val),
         .p0_req_rdy   (p0_req_rdy_a[g]),
         .p0_req_we    (p0_req_we),
         .p0_req_addr  (p0_req_addr),
         .p0_req_wdata (p0_req_wdata),
         .p0_rsp_val   (p0_rsp_val_a[g]),
         .p0_rsp_data  (p0_rsp_data_a[g]),
         .p1_req_val   (p1_req_val),
         .p1_req_rdy   (p1_req_rdy_a[g]),
         .p1_req_we    (p1_req_we),
         .p1_req_addr  (p1_req_addr),
         .p1_req_wdata (p1_req_wdata),
         .p1_rsp_val   (p1_rsp_val_a[g]),
         .p1_rsp_data  (p1_rsp_data_a[g]),
         .arr_rd       (arr_rd_a[g]),
         .arr_wr       (arr_wr_a[g]),
         .arr_addr     (arr_addr_a[g]),
         .arr_wdata    (arr_wdata_a[g]),
         .arr_rdata    (rdata),
         .phase_err    (phase_err_a[g])
      );
   end

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
      if (tgl) el_sel = ~el_sel;
   endtask

   task automatic mid();
      @(negedge clk);
   endtask

   task automatic idle_inputs();
      p0_req_val = 1'b0; p0_req_we = 1'b0;
      p1_req_val = 1'b0; p1_req_we = 1'b0;
   endtask

   // Leaves the bench early in the first cycle after release with el_sel = 0.
   task automatic do_reset();
      @(posedge clk);
      #1;
      reset_n = 1'b0;
      tgl = 1'b0;
      el_sel = 1'b0;
      idle_inputs();
      mid();
      check("rst_rdy", 32'({p1_req_rdy_a, p0_req_rdy_a}), 32'h0);
      check("rst_arr", 32'({arr_rd_a, arr_wr_a}), 32'h0);
      check("rst_rsp_val", 32'({p1_rsp_val_a, p0_rsp_val_a}), 32'h0);
      check("rst_rsp_data", p0_rsp_data_a[0] | p0_rsp_data_a[1] | p0_rsp_data_a[2] |
                            p1_rsp_data_a[0] | p1_rsp_data_a[1] | p1_rsp_data_a[2], 32'h0);
      check("rst_phase_err", 32'(phase_err_a), 32'h0);
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      el_sel = 1'b0;
      tgl = 1'b1;
      #2;
      check("rel_rdy", 32'({p1_req_rdy_a, p0_req_rdy_a}), 32'h3f);
   endtask

   initial begin
      #100000;
      $display("FAIL timeout: bench did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      logic [2:0] e_val [6];
      logic [5:0] e0, e1;
      int n0, n1, r0, r1;
      logic any_rsp, any_iss;

      // Write then read addr 5 through port 0.
      do_reset();
      p0_req_val = 1'b1; p0_req_we = 1'b1; p0_req_addr = 6'd5; p0_req_wdata = 32'hA5A5_A5A5;
      next_cycle();
      p0_req_we = 1'b0;
      mid();
      check("wr_wait_slot", 32'(arr_rd_a | arr_wr_a), 32'h0);
      next_cycle();
      p0_req_val = 1'b0;
      mid();
      check("wr_issue", 32'(arr_wr_a), 32'h7);
      check("wr_no_rd", 32'(arr_rd_a), 32'h0);
      check("wr_addr", 32'(arr_addr_a[0]), 32'd5);
      check("wr_data", arr_wdata_a[0], 32'hA5A5_A5A5);
      next_cycle();
      mid();
      check("wr_gap", 32'(arr_rd_a | arr_wr_a), 32'h0);
      next_cycle();
      mid();
      check("rd_issue", 32'(arr_rd_a), 32'h7);
      check("rd_addr", 32'(arr_addr_a[0]), 32'd5);
      e_val = '{3'b000, 3'b001, 3'b000, 3'b010, 3'b100, 3'b000};
      for (int i = 0; i < 6; i++) begin
         next_cycle();
         mid();
         check($sformatf("rd_p0_val_c%0d", i + 6), 32'(p0_rsp_val_a), 32'(e_val[i]));
         check($sformatf("rd_p1_val_c%0d", i + 6), 32'(p1_rsp_val_a), 32'h0);
      end
      for (int g = 0; g < 3; g++)
         check($sformatf("rd_data_lat%0d", g), p0_rsp_data_a[g], 32'hA5A5_A5A5);

      // Both ports stream 8 reads each with el_sel toggling.
      do_reset();
      n0 = 0; n1 = 0; r0 = 0; r1 = 0;
      for (int c = 1; c <= 21; c++) begin
         if (c > 1) next_cycle();
         p0_req_val = (n0 < 8); p0_req_addr = 6'(16 + n0);
         p1_req_val = (n1 < 8); p1_req_addr = 6'(48 + n1);
         mid();
         if (c >= 2 && c <= 17) begin
            check($sformatf("b2b_iss_c%0d", c), 32'(arr_rd_a[0]), 32'h1);
            check($sformatf("b2b_addr_c%0d", c), 32'(arr_addr_a[0]),
                  (c % 2 == 0) ? 32'(48 + (c - 2) / 2) : 32'(16 + (c - 3) / 2));
         end
         if (p0_rsp_val_a[0]) begin
            check($sformatf("b2b_p0_rsp%0d", r0), p0_rsp_data_a[0], pat(16 + r0));
            r0++;
         end
         if (p1_rsp_val_a[0]) begin
            check($sformatf("b2b_p1_rsp%0d", r1), p1_rsp_data_a[0], pat(48 + r1));
            r1++;
         end
         if (p0_req_val && p0_req_rdy_a[0]) n0++;
         if (p1_req_val && p1_req_rdy_a[0]) n1++;
      end
      idle_inputs();
      check("b2b_p0_count", 32'(r0), 32'd8);
      check("b2b_p1_count", 32'(r1), 32'd8);

      // Port 1 fills its FIFO while el_sel is held at 0.
      do_reset();
      tgl = 1'b0;
      p1_req_val = 1'b1; p1_req_addr = 6'd48;
      mid();
      check("fill_rdy_0", 32'(p1_req_rdy_a), 32'h7);
      next_cycle();
      p1_req_addr = 6'd49;
      mid();
      check("fill_rdy_1", 32'(p1_req_rdy_a), 32'h7);
      check("fill_no_issue", 32'(arr_rd_a), 32'h0);
      next_cycle();
      p1_req_addr = 6'd50;
      mid();
      check("fill_full", 32'(p1_req_rdy_a), 32'h0);
      next_cycle();
      mid();
      check("fill_full_hold", 32'(p1_req_rdy_a), 32'h0);
      check("fill_phase_err", 32'(phase_err_a), 32'h7);
      tgl = 1'b1;
      next_cycle();
      mid();
      check("drain_issue", 32'(arr_rd_a), 32'h7);
      check("drain_addr", 32'(arr_addr_a[0]), 32'd48);
      check("drain_rdy_still0", 32'(p1_req_rdy_a), 32'h0);
      next_cycle();
      mid();
      check("third_rdy", 32'(p1_req_rdy_a), 32'h7);
      next_cycle();
      p1_req_val = 1'b0;
      mid();
      check("second_issue", 32'(arr_rd_a), 32'h7);
      check("second_addr", 32'(arr_addr_a[0]), 32'd49);
      next_cycle();
      mid();
      check("p0_slot_idle", 32'(arr_rd_a | arr_wr_a), 32'h0);
      next_cycle();
      mid();
      check("third_issue", 32'(arr_rd_a), 32'h7);
      check("third_addr", 32'(arr_addr_a[0]), 32'd50);

      // el_sel stuck at 0 for two cycles with a port 0 request pending.
      do_reset();
      tgl = 1'b0;
      p0_req_val = 1'b1; p0_req_we = 1'b0; p0_req_addr = 6'd20;
      mid();
      check("stuck_perr_init", 32'(phase_err_a), 32'h0);
      next_cycle();
      p0_req_val = 1'b0;
      mid();
      check("stuck_no_issue", 32'(arr_rd_a | arr_wr_a), 32'h0);
      check("stuck_perr_pre", 32'(phase_err_a), 32'h0);
      tgl = 1'b1;
      next_cycle();
      mid();
      check("stuck_perr_set", 32'(phase_err_a), 32'h7);
      check("stuck_p1_slot", 32'(arr_rd_a), 32'h0);
      next_cycle();
      mid();
      check("stuck_late_issue", 32'(arr_rd_a), 32'h7);
      check("stuck_late_addr", 32'(arr_addr_a[0]), 32'd20);
      for (int i = 0; i < 3; i++) begin
         next_cycle();
         mid();
         check($sformatf("stuck_perr_sticky%0d", i), 32'(phase_err_a), 32'h7);
      end

      // Reset pulsed one cycle after a read issue; queued p1 request is dropped.
      do_reset();
      p0_req_val = 1'b1; p0_req_we = 1'b0; p0_req_addr = 6'd16;
      next_cycle();
      p0_req_val = 1'b0;
      next_cycle();
      p1_req_val = 1'b1; p1_req_addr = 6'd48;
      mid();
      check("pulse_pre_issue", 32'(arr_rd_a), 32'h7);
      next_cycle();
      reset_n = 1'b0;
      p1_req_val = 1'b0;
      mid();
      check("pulse_rdy_low", 32'({p1_req_rdy_a, p0_req_rdy_a}), 32'h0);
      check("pulse_rsp_low", 32'({p1_rsp_val_a, p0_rsp_val_a}), 32'h0);
      next_cycle();
      reset_n = 1'b1;
      el_sel = 1'b0;
      #2;
      check("pulse_rdy_rel", 32'({p1_req_rdy_a, p0_req_rdy_a}), 32'h3f);
      any_rsp = 1'b0; any_iss = 1'b0;
      for (int i = 0; i < 12; i++) begin
         mid();
         any_rsp |= |{p0_rsp_val_a, p1_rsp_val_a};
         any_iss |= |{arr_rd_a, arr_wr_a};
         next_cycle();
      end
      check("pulse_no_rsp", 32'(any_rsp), 32'h0);
      check("pulse_fifo_empty", 32'(any_iss), 32'h0);

      // RD_LAT=4 routing: reads from ports 0,1,0,1 in consecutive cycles.
      do_reset();
      p0_req_val = 1'b1; p0_req_we = 1'b0; p0_req_addr = 6'd16;
      next_cycle();
      p0_req_addr = 6'd17;
      p1_req_val = 1'b1; p1_req_we = 1'b0; p1_req_addr = 6'd48;
      next_cycle();
      p0_req_val = 1'b0;
      p1_req_addr = 6'd49;
      mid();
      check("l4_iss_p0a", 32'({arr_rd_a[2], arr_addr_a[2]}), 32'h40 | 32'd16);
      next_cycle();
      p1_req_val = 1'b0;
      mid();
      check("l4_iss_p1a", 32'({arr_rd_a[2], arr_addr_a[2]}), 32'h40 | 32'd48);
      next_cycle();
      mid();
      check("l4_iss_p0b", 32'({arr_rd_a[2], arr_addr_a[2]}), 32'h40 | 32'd17);
      next_cycle();
      mid();
      check("l4_iss_p1b", 32'({arr_rd_a[2], arr_addr_a[2]}), 32'h40 | 32'd49);
      e0 = 6'b001010;
      e1 = 6'b010100;
      for (int i = 0; i < 6; i++) begin
         next_cycle();
         mid();
         check($sformatf("l4_p0_val_c%0d", i + 7), 32'(p0_rsp_val_a[2]), 32'(e0[i]));
         check($sformatf("l4_p1_val_c%0d", i + 7), 32'(p1_rsp_val_a[2]), 32'(e1[i]));
         if (e0[i]) check($sformatf("l4_p0_data_c%0d", i + 7), p0_rsp_data_a[2], pat(16 + (i - 1) / 2));
         if (e1[i]) check($sformatf("l4_p1_data_c%0d", i + 7), p1_rsp_data_a[2], pat(48 + (i - 2) / 2));
      end
      check("l4_p0_held", p0_rsp_data_a[2], pat(17));
      check("l4_p1_held", p1_rsp_data_a[2], pat(49));

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/ra_ddr_seq.md
RA_DDR_SEQ -- requirements
Module: ra_ddr_seq

Interface
REQ-001 SHALL have parameter ADDR_W, default 6, array address width.
REQ-002 SHALL have parameter DATA_W, default 32, array data width.
REQ-003 SHALL have parameter RD_LAT, default 1 (legal 1..4), clk cycles from arr_rd to valid arr_rdata.
REQ-004 SHALL have port clk  in  1  2x array clock, same clock as the upstream LCB.
REQ-005 SHALL have port reset_n  in  1  reset, asynchronous and active-low.
REQ-006 SHALL have port el_sel  in  1  LCB phase: 0 = early slot (port 0), 1 = late slot (port 1).
REQ-007 SHALL have ports pK_req_val  in  1, pK_req_rdy  out  1, pK_req_we  in  1, pK_req_addr  in  ADDR_W, pK_req_wdata  in  DATA_W, for K = 0,1.
REQ-008 SHALL have ports pK_rsp_val  out  1 and pK_rsp_data  out  DATA_W, for K = 0,1 (read return, no backpressure).
REQ-009 SHALL have ports arr_rd  out  1, arr_wr  out  1, arr_addr  out  ADDR_W, arr_wdata  out  DATA_W.
REQ-010 SHALL have port arr_rdata  in  DATA_W  array read data.
REQ-011 SHALL have port phase_err  out  1  sticky el_sel protocol error.

Function
REQ-012 SHALL give each port a 2-entry FIFO of {we, addr, wdata}; pK_req_rdy = FIFO not full.
REQ-013 SHALL push when pK_req_val & pK_req_rdy at a rising clk; the value of pK_req_val while rdy=0 SHALL be ignored.
REQ-014 SHALL own the slot for port 0 when el_sel=0 and for port 1 when el_sel=1; no cross-port borrowing of idle slots.
REQ-015 SHALL issue in a cycle when the owning FIFO is non-empty and no phase error is detected that cycle: arr_addr = head addr, arr_rd = !head.we, arr_wr = head.we, arr_wdata = head.wdata (combinational from head).
REQ-016 SHALL keep arr_rd = arr_wr = 0 in non-issuing cycles; arr_addr/arr_wdata are don't-care there.
REQ-017 SHALL pop the head at the rising edge that ends an issue cycle.
REQ-018 SHALL allow push and pop in the same cycle at count 1 (count stays 1); at count 2 only pop is possible.
REQ-019 SHALL preserve per-port request order; write data is never returned.
REQ-020 SHALL track each read in a RD_LAT-deep {valid, port} shift pipeline; issue in cycle N → arr_rdata sampled at end of cycle N+RD_LAT → pK_rsp_val high for exactly cycle N+RD_LAT+1, pK_rsp_data registered and held until the next response for that port.
REQ-021 SHALL support back-to-back reads alternating ports every cycle at full rate.
REQ-022 SHALL flag a phase error when el_sel equals its value from the previous cycle, checked from the second cycle after reset release onward.
REQ-023 SHALL suppress issue in a cycle with a phase error (no pop) and set phase_err, which stays 1 until reset.
REQ-024 SHALL ensure in-flight reads complete normally regardless of later phase errors.

Reset
REQ-025 SHALL, while reset_n=0, clear both FIFOs, the read pipeline and phase_err immediately.
REQ-026 SHALL, while reset_n=0, drive pK_req_rdy=0, arr_rd=arr_wr=0, pK_rsp_val=0 and pK_rsp_data=0.
REQ-027 SHALL drop requests that are queued or in flight when reset_n asserts mid-operation; no response SHALL follow reset release.
REQ-028 SHALL set pK_req_rdy=1 in the first cycle after reset_n deasserts.

Verification
REQ-029 SHALL cover: p0 write addr 5 data 0xA5A5A5A5, then p0 read addr 5, RD_LAT=1 → arr_wr in the el_sel=0 cycle; p0_rsp_val 2 cycles after the read issue with data 0xA5A5A5A5.
REQ-030 SHALL cover: both ports read every cycle for 16 cycles, el_sel toggling → reads issued in every cycle, alternating ports; 8 responses per port, in order.
REQ-031 SHALL cover: p1 pushes 3 requests while el_sel is held so that the late slot is missed → p1_req_rdy=0 after 2 pushes; the third is accepted only after a pop.
REQ-032 SHALL cover: el_sel stuck at 0 for 2 cycles with a p0 request pending → no issue in the second cycle, phase_err=1 and remaining 1 until reset.
REQ-033 SHALL cover: reset_n pulsed low one cycle after a read issue with RD_LAT=3 → no pK_rsp_val ever seen, FIFOs empty, rdy=1 after release.
REQ-034 SHALL cover: RD_LAT=4 with reads from ports 0,1,0,1 on consecutive cycles → each response is routed to its issuing port, 5 cycles after its issue.
